// File: rtl/mmio_master.sv
// rtl/mmio_master.sv - single-word MMIO bus initiator (optional timeout: MMIO_TIMEOUT_EN)
module mmio_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mmio_read,
    output logic        mmio_write,
    output logic [31:0] mmio_addr,
    output logic [31:0] mmio_write_data,
    input  logic        mmio_work,
    input  logic        mmio_done,
    input  logic [31:0] mmio_read_data
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        rv_q, rv_d, err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    // first_q marks the first BUSY cycle, where the address claim is sampled
    logic        first_q, first_d;
    logic        unclaimed_q, unclaimed_d;
`ifdef MMIO_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Reject out-of-range configurations at elaboration
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_timeout
        $error("mmio_master: TIMEOUT_CYCLES out of range for CNT_W");
    end

    assign req_ready       = rst_n & (state_q == IDLE);
    assign resp_valid      = rv_q;
    assign resp_err        = err_q;
    assign resp_rdata      = rdata_q;
    assign mmio_read       = rd_q;
    assign mmio_write      = wr_q;
    assign mmio_addr       = addr_q;
    assign mmio_write_data = wdata_q;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rv_d        = 1'b0;
        err_d       = 1'b0;
        rdata_d     = 32'd0;
        first_d     = first_q;
        unclaimed_d = unclaimed_q;
`ifdef MMIO_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d     = BUSY;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    wr_d        = req_write;
                    rd_d        = ~req_write;
                    first_d     = 1'b1;
                    unclaimed_d = 1'b0;
`ifdef MMIO_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            BUSY: begin
                first_d = 1'b0;
                if (first_q) begin
                    unclaimed_d = ~mmio_work;
                end
                // Done wins over both error sources; strobes drop on the sampling edge
                if (mmio_done) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rv_d    = 1'b1;
                    rdata_d = rd_q ? mmio_read_data : 32'd0;
                end else if (unclaimed_q) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rv_d    = 1'b1;
                    err_d   = 1'b1;
                end
`ifdef MMIO_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rv_d    = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared by asynchronous reset
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rv_q        <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            first_q     <= 1'b0;
            unclaimed_q <= 1'b0;
`ifdef MMIO_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rv_q        <= rv_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            first_q     <= first_d;
            unclaimed_q <= unclaimed_d;
`ifdef MMIO_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mmio_master.sv
// tb/tb_mmio_master.sv - scoreboard bench for mmio_master
module tb_mmio_master;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err, mmio_read, mmio_write;
    logic [31:0] resp_rdata, mmio_addr, mmio_write_data, mmio_read_data;
    logic        mmio_work, mmio_done, claim;
    logic        rsp_done_q;
    logic        rsp_silent = 1'b0;
    logic        extra_done = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          cyc;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;
    exp_t sb[$];

    mmio_master #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mmio_read(mmio_read), .mmio_write(mmio_write), .mmio_addr(mmio_addr),
        .mmio_write_data(mmio_write_data), .mmio_work(mmio_work),
        .mmio_done(mmio_done), .mmio_read_data(mmio_read_data)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Responder claiming 0xFFFF0200-0xFFFF027F, done one cycle after the strobe, returns 1
    assign claim = (mmio_addr >= 32'hFFFF0200) && (mmio_addr <= 32'hFFFF027F);
    assign mmio_work = claim;
    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) rsp_done_q <= 1'b0;
        else        rsp_done_q <= (mmio_read | mmio_write) & claim & ~rsp_done_q & ~rsp_silent;
    end
    assign mmio_done = rsp_done_q | extra_done;
    assign mmio_read_data = rsp_done_q ? 32'h1 : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected responses and checks the bus around each one
    logic prev_rd = 0, prev_wr = 0, prev_done = 0, prev_rv = 0;
    always @(negedge sys_clk) begin
        if (rst_n) begin
            if (prev_done) chk("strobe_after_done", {31'd0, mmio_read | mmio_write}, 32'd0);
            if (resp_valid) begin
                chk("resp_pulse_single", {31'd0, prev_rv}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got resp_valid=1 want 0");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_cycle", cyc, e.cyc);
                    chk("strobe_rd_before", {31'd0, prev_rd}, {31'd0, !e.wr});
                    chk("strobe_wr_before", {31'd0, prev_wr}, {31'd0, e.wr});
                    chk("strobe_off_at_resp", {30'd0, mmio_read, mmio_write}, 32'd0);
                    chk("mmio_addr", mmio_addr, e.addr);
                    chk("mmio_wdata", mmio_write_data, e.wdata);
                end
            end else begin
                chk("idle_err", {31'd0, resp_err}, 32'd0);
                chk("idle_rdata", resp_rdata, 32'd0);
            end
            prev_rd   <= mmio_read;
            prev_wr   <= mmio_write;
            prev_done <= mmio_done;
            prev_rv   <= resp_valid;
        end else begin
            prev_rd   <= 1'b0;
            prev_wr   <= 1'b0;
            prev_done <= 1'b0;
            prev_rv   <= 1'b0;
        end
    end

    // Present a request at a negedge; returns at the negedge after acceptance
    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input bit exp_err, input logic [31:0] exp_rd, input int lat,
                         input bit push, output int acc);
        int n = 0;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        acc = cyc + 1;
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_wait: got req_ready=0 want 1 within 50 cycles");
        end else if (push) begin
            sb.push_back('{exp_err, exp_rd, acc + lat, wr, a, d});
        end
        @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_strobes"}, {30'd0, mmio_read, mmio_write}, 32'd0);
        chk({tag, "_addr"}, mmio_addr, 32'd0);
        chk({tag, "_wdata"}, mmio_write_data, 32'd0);
    endtask

    initial begin
        int a1, a2;
        #12;
        chk_all_zero("reset");
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

        issue(1'b0, 32'hFFFF0204, 32'd0, 1'b0, 32'h1, 2, 1'b1, a1);
        chk("load_rd_strobe", {30'd0, mmio_read, mmio_write}, 32'd2);
        chk("load_addr", mmio_addr, 32'hFFFF0204);
        idle(3);

        issue(1'b1, 32'hFFFF0208, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1'b1, a1);
        chk("store_wr_strobe", {30'd0, mmio_read, mmio_write}, 32'd1);
        chk("store_wdata", mmio_write_data, 32'hDEADBEEF);
        idle(3);

        issue(1'b0, 32'h10000000, 32'd0, 1'b1, 32'h0, 2, 1'b1, a1);
        idle(4);
        chk("unclaimed_no_strobe", {30'd0, mmio_read, mmio_write}, 32'd0);

        issue(1'b0, 32'hFFFF0210, 32'd0, 1'b0, 32'h1, 2, 1'b1, a1);
        issue(1'b0, 32'hFFFF0220, 32'd0, 1'b0, 32'h1, 2, 1'b1, a2);
        chk("b2b_accept_cycle", a2, a1 + 3);
        idle(4);

        // done pulse while idle must be ignored
        extra_done = 1'b1;
        @(negedge sys_clk);
        extra_done = 1'b0;
        idle(3);

`ifdef MMIO_TIMEOUT_EN
        rsp_silent = 1'b1;
        issue(1'b0, 32'hFFFF0230, 32'd0, 1'b1, 32'h0, 4, 1'b1, a1);
        idle(12);
        extra_done = 1'b1;
        @(negedge sys_clk);
        extra_done = 1'b0;
        idle(3);
        rsp_silent = 1'b0;
`endif

        issue(1'b0, 32'hFFFF0240, 32'd0, 1'b0, 32'h0, 2, 1'b0, a1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        #1 rst_n = 1'b1;
        req_valid = 1'b0;
        @(negedge sys_clk);
        chk("ready_after_midreset", {31'd0, req_ready}, 32'd1);
        idle(5);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mmio_master.md
Name: mmio_master

Overview:
Initiator side of the single-word MMIO bus.
- Accepts one load/store request at a time from the CPU memory stage.
- Drives mmio_read/mmio_write/mmio_addr/mmio_write_data toward the peripherals and waits for a device's one-cycle mmio_done pulse.
- Returns read data or an error response to the CPU.
- Peripheral mmio_work, mmio_done and mmio_read_data are OR-combined outside this block. Idle peripherals drive 0.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in BUSY before an error response (only with the optional feature); legal range 2..2^CNT_W-1
CNT_W, 8, width of the timeout counter

Ports:
sys_clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  CPU request present
req_ready  out  1  block can accept a request this cycle
req_write  in  1  1=store, 0=load
req_addr  in  32  byte address
req_wdata  in  32  store data
resp_valid  out  1  one-cycle response pulse
resp_err  out  1  with resp_valid: unclaimed address or timeout
resp_rdata  out  32  load data, valid with resp_valid
mmio_read  out  1  registered read strobe
mmio_write  out  1  registered write strobe
mmio_addr  out  32  registered address
mmio_write_data  out  32  registered write data
mmio_work  in  1  OR of device address-claim signals (combinational from mmio_addr)
mmio_done  in  1  OR of device done pulses
mmio_read_data  in  32  OR of device read data, valid while mmio_done=1

Behaviour:
- Reset (async, rst_n=0): state=IDLE, every output and counter 0 (req_ready=0 only while rst_n=0).
- req_ready = (state==IDLE). A request is accepted on an edge with req_valid&req_ready.
- States: IDLE, BUSY. All outputs are registered.
- IDLE -> BUSY on accept:
  - Latch req_addr/req_wdata into mmio_addr/mmio_write_data.
  - Set mmio_write=req_write and mmio_read=!req_write.
  - Clear the counter.
- BUSY, first cycle (counter==0): if mmio_work==0, the address is unclaimed.
  - Next edge: strobes go to 0, resp_valid=1, resp_err=1, resp_rdata=0, state goes to IDLE.
- BUSY, mmio_done==1 at an edge:
  - Strobes go to 0, resp_valid=1, resp_err=0, state goes to IDLE.
  - resp_rdata = mmio_read_data for a load, 0 for a store.
- Strobes hold steady until done, error or timeout. They drop on the same edge that samples done, so a responder never sees a strobe while its own done is high.
- Nominal latency: accept at edge N, device done at N+1, resp_valid high in the cycle after edge N+2.
- Unclaimed-address error has the same latency.
- resp_valid and resp_err are single-cycle pulses. resp_rdata returns to 0 the cycle after.
- Back-to-back: in the resp_valid cycle req_ready=1, and a new request may be accepted on that edge.
- mmio_done arriving in IDLE (late, after a timeout) is ignored and produces no response.
- mmio_done together with counter==0 and mmio_work==0 cannot legally occur. If it does, done takes priority.
- mmio_addr and mmio_write_data keep their last values in IDLE.
- Reset mid-BUSY aborts the transaction and produces no response.

Optional Feature:
MMIO_TIMEOUT_EN
- Defined:
  - The counter increments every BUSY cycle without done.
  - When counter==TIMEOUT_CYCLES-1 and done is still absent, the next edge drops the strobes and gives resp_valid=1, resp_err=1, resp_rdata=0, state IDLE.
  - Done on the same edge wins over timeout.
- Undefined: no counter logic; BUSY waits indefinitely for mmio_done.

Test Plan:
- Load 0xFFFF0204 with a responder model claiming 0xFFFF0200-0xFFFF027F that returns 1 one cycle after the strobe -> mmio_read high 2 cycles; resp_valid one pulse 2 cycles after accept; resp_rdata=0x00000001, resp_err=0.
- Store 0xFFFF0208 data 0xDEADBEEF -> mmio_write high with mmio_write_data=0xDEADBEEF; resp_valid, resp_err=0, resp_rdata=0; mmio_read stays 0.
- Load 0x10000000 (mmio_work=0) -> resp_valid+resp_err 2 cycles after accept, rdata=0; no strobe after that.
- Two loads with req_valid held high -> second accepted in the first's resp_valid cycle; responder never sees a strobe while its done is high; both responses correct.
- With MMIO_TIMEOUT_EN, TIMEOUT_CYCLES=4, claiming device never asserts done -> resp_err pulse exactly 4 cycles after the first BUSY cycle; a done pulse 10 cycles later is ignored.
- Assert rst_n=0 mid-BUSY, asynchronously between edges -> all outputs 0 immediately; after release state=IDLE, req_ready=1, no stale resp_valid.
